// File: rtl/restoring_divider.sv
// Iterative restoring divider: one quotient bit per cycle, start/done handshake.
// Optional signed mode enabled by defining RESTORING_DIVIDER_SIGNED_EN.
module restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef RESTORING_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             sgn_op;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_q;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    assign sgn_op = signed_op;
`else
    assign sgn_op = 1'b0;
`endif

    // Operand magnitudes for the unsigned core, and one restoring step.
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        if (sgn_op && dividend[WIDTH-1]) dvd_mag = -dividend;
        if (sgn_op && divisor[WIDTH-1]) dvs_mag = -divisor;
        // Shifted remainder can reach 2*divisor-1, so keep an extra bit.
        shifted  = {rem_acc, q_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        fits     = ~trial[WIDTH];
        next_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_q   = {q_reg[WIDTH-2:0], fits};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            rem_acc     <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q_reg   <= dvd_mag;
                        dvs     <= dvs_mag;
                        rem_acc <= '0;
                        cnt     <= CNT_MAX;
                        neg_q   <= sgn_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r   <= sgn_op & dividend[WIDTH-1];
                        if (divisor == '0) begin
                            // No iterations needed: report immediately.
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    rem_acc <= next_rem;
                    q_reg   <= next_q;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                        quotient    <= neg_q ? -next_q : next_q;
                        remainder   <= neg_r ? -next_rem : next_rem;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with a result scoreboard.
// Signed cases run when RESTORING_DIVIDER_SIGNED_EN is defined.
module tb_restoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   passes = 0;
    int   checks = 0;

    restoring_divider #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef RESTORING_DIVIDER_SIGNED_EN
        .signed_op(signed_op),
`endif
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive a request at a falling edge; it is accepted at the next rising edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit sop);
        exp_t e;
        int signed sa;
        int signed sb_v;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sop) begin
            sa   = a;
            sb_v = b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = sa / sb_v;
                e.r = sa % sb_v;
            end
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        sb.push_back(e);
        dividend  = a;
        divisor   = b;
        signed_op = sop;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Wait for done, then check latency, busy span and scoreboard head.
    task automatic wait_done(input string tag, input int lat, input int bz);
        int   n = 0;
        int   bn = 0;
        exp_t e;
        do begin
            @(negedge clk);
            n++;
            if (busy) bn++;
        end while (!done && n < 100);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy cycles"}, 64'(bn), 64'(bz));
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({tag, " quotient"}, 64'(quotient), 64'(e.q));
            chk({tag, " remainder"}, 64'(remainder), 64'(e.r));
            chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
        end
    endtask

    initial begin
        int dn;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset quotient", 64'(quotient), 64'(0));
        chk("reset remainder", 64'(remainder), 64'(0));
        chk("reset div_by_zero", 64'(div_by_zero), 64'(0));

        drive(32'd100, 32'd7, 1'b0);
        wait_done("100/7", 33, 32);
        @(negedge clk);
        chk("done single pulse", 64'(done), 64'(0));
        chk("result holds", 64'(quotient), 64'(14));

        drive(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done("ffffffff/1", 33, 32);
        drive(32'd5, 32'd9, 1'b0);
        wait_done("5/9 back-to-back", 33, 32);

        @(negedge clk);
        drive(32'd1234, 32'd0, 1'b0);
        wait_done("1234/0", 1, 0);
        @(negedge clk);
        chk("div0 done pulse", 64'(done), 64'(0));
        chk("div0 flag holds", 64'(div_by_zero), 64'(1));

        drive(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        chk("mid calc busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst quotient", 64'(quotient), 64'(0));
        chk("rst remainder", 64'(remainder), 64'(0));
        chk("rst div_by_zero", 64'(div_by_zero), 64'(0));
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no done after rst", 64'(dn), 64'(0));
        drive(32'd9, 32'd3, 1'b0);
        wait_done("9/3", 33, 32);

        @(negedge clk);
        drive(32'd3, 32'd10, 1'b0);
        wait_done("3/10", 33, 32);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive($urandom, $urandom_range(1, 65535), 1'b0);
            wait_done("random", 33, 32);
        end

`ifdef RESTORING_DIVIDER_SIGNED_EN
        @(negedge clk);
        drive(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("signed -7/2", 33, 32);
        @(negedge clk);
        drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("signed min/-1", 33, 32);
        @(negedge clk);
        drive(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("signed 7/-2", 33, 32);
        @(negedge clk);
        drive(32'hFFFF_FB2E, 32'd0, 1'b1);
        wait_done("signed -1234/0", 1, 0);
        @(negedge clk);
        drive(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("unsigned big/2", 33, 32);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Iterative 32-bit divider built on repeated subtraction, the inverse of the team's prefix adders.
- Produces one quotient bit per cycle, using a WIDTH+1-bit trial subtract (remainder minus divisor).
- Sits beside the adder in the ALU32 datapath and serves DIV/REM operations through a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; latched when start is accepted.
- divisor  input  WIDTH  denominator; latched when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  single-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with done when the latched divisor == 0.

Interface (already decided): one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- Reset: state=IDLE. busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, iteration counter=0. rst has priority over everything, including mid-CALC; a partial result is discarded and done is never raised for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1: latch operands, clear internal remainder accumulator, counter=WIDTH-1.
  - Latched divisor != 0 -> CALC.
  - Latched divisor == 0 -> DONE directly.
- CALC, each cycle:
  - Shift {rem_acc, q_reg} left by 1.
  - Trial = shifted rem_acc - divisor, computed WIDTH+1 bits wide.
  - Trial non-negative: rem_acc=trial and q bit=1; else restore (keep rem_acc) and q bit=0.
  - Counter decrements; the cycle with counter==0 moves to DONE.
  - Exactly WIDTH cycles in CALC. busy=1 throughout CALC only.
  - start is ignored in CALC; operand inputs may change freely.
- DONE (one cycle):
  - done=1; quotient/remainder registers updated this cycle.
  - div_by_zero=1 iff divisor was 0. In that case quotient=all ones and remainder=dividend.
  - Next state IDLE, or, if start=1 in this cycle, accept the new operation (same rules as IDLE) back-to-back.
- Latency: start accepted at edge N -> done high during cycle N+WIDTH+1, i.e. 33 cycles for WIDTH=32; divide-by-zero done at N+1.
- Results and div_by_zero hold their values until the next DONE or reset; done itself is never high two consecutive cycles except for back-to-back operations.
- Unsigned arithmetic throughout; dividend < divisor gives quotient=0, remainder=dividend.
- Identity: quotient*divisor + remainder == dividend with remainder < divisor for every non-zero divisor.

Optional Feature:
- Macro: RESTORING_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), latched with start.
  - When signed_op=1: operands are converted to magnitudes on accept; the core runs unsigned; in DONE, quotient sign = sign(dividend) XOR sign(divisor) and remainder takes the sign of the dividend (truncating division).
  - Overflow case: most negative dividend / -1 gives quotient=most negative value, remainder=0, no flag.
  - Divide by zero still yields quotient=all ones, remainder=dividend.
  - Latency unchanged.
- Undefined: no signed_op port; purely unsigned as above.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- start with 100/7 -> busy for 32 cycles, done exactly 33 cycles after accept, quotient=14, remainder=2.
- 0xFFFFFFFF/1 then, via start during DONE, 5/9 back-to-back -> first quotient=0xFFFFFFFF, remainder=0; second quotient=0, remainder=5; no idle gap.
- 1234/0 -> done next cycle, div_by_zero=1, quotient=0xFFFFFFFF, remainder=1234.
- start 100/7, assert rst on CALC cycle 10 -> all outputs 0, no done pulse; new start 9/3 completes with quotient=3, remainder=0.
- With RESTORING_DIVIDER_SIGNED_EN, signed_op=1: -7/2 -> quotient=-3, remainder=-1; 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
